// File: rtl/counter_mod_if.sv
// rtl/counter_mod_if.sv - control and status bundle for counter_mod
interface counter_mod_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr;
    logic [WIDTH-1:0] y;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, d, clr,
        input  y, tc, ovf
    );

    modport slave (
        input  en, up, load, d, clr,
        output y, tc, ovf
    );
endinterface

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - prescaled up/down range counter with wrap/saturate, tc pulse and sticky ovf
module counter_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 255,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          res,
    counter_mod_if.slave  bus
);
    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX);
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] y_q;
    logic [PW-1:0]    pre_q;
    logic             tc_q;
    logic             ovf_q;

    logic             at_limit;
    logic [WIDTH-1:0] y_step;

    // Limits are checked before the add/subtract so nothing ever leaves WIDTH bits.
    always_comb begin
        y_step   = y_q;
        at_limit = 1'b0;
        if (bus.up) begin
            if (y_q >= MAXV) begin
                at_limit = 1'b1;
                y_step   = (SATURATE != 0) ? MAXV : '0;
            end else begin
                y_step = y_q + WIDTH'(1);
            end
        end else begin
            if (y_q == '0) begin
                at_limit = 1'b1;
                y_step   = (SATURATE != 0) ? '0 : MAXV;
            end else begin
                y_step = y_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res || bus.clr) begin
            y_q   <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (bus.load) begin
            y_q   <= (bus.d > MAXV) ? MAXV : bus.d;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else if (bus.en) begin
            if (pre_q == PLAST) begin
                pre_q <= '0;
                y_q   <= y_step;
                tc_q  <= at_limit;
                if (at_limit) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                pre_q <= pre_q + PW'(1);
                tc_q  <= 1'b0;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.y   = y_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - scoreboard bench for counter_mod across wrap, saturate and prescale builds
module tb_counter_mod;
    localparam int W = 8;

    typedef struct {
        int           dut;
        logic [W+1:0] val;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    counter_mod_if #(.WIDTH(W)) b0 ();
    counter_mod_if #(.WIDTH(W)) b1 ();
    counter_mod_if #(.WIDTH(W)) b2 ();

    counter_mod #(.WIDTH(W), .MAX(9), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .res(res), .bus(b0)
    );
    counter_mod #(.WIDTH(W), .MAX(9), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .res(res), .bus(b1)
    );
    counter_mod #(.WIDTH(W), .MAX(255), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .res(res), .bus(b2)
    );

    function automatic logic [W+1:0] observe(input int dut);
        case (dut)
            0:       return {b0.y, b0.tc, b0.ovf};
            1:       return {b1.y, b1.tc, b1.ovf};
            default: return {b2.y, b2.tc, b2.ovf};
        endcase
    endfunction

    task automatic expect_out(input int dut, input int y, input bit tc, input bit ovf, input string tag);
        exp_t e;
        e.dut = dut;
        e.val = {W'(y), tc, ovf};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t         e;
        logic [W+1:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.dut);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s dut%0d: observed y=%0d tc=%0b ovf=%0b expected y=%0d tc=%0b ovf=%0b",
                       e.tag, e.dut, obs[W+1:2], obs[1], obs[0], e.val[W+1:2], e.val[1], e.val[0]);
            end
        end
    endtask

    initial begin
        b0.en = 0; b0.up = 1; b0.load = 0; b0.d = '0; b0.clr = 0;
        b1.en = 0; b1.up = 1; b1.load = 0; b1.d = '0; b1.clr = 0;
        b2.en = 0; b2.up = 1; b2.load = 0; b2.d = '0; b2.clr = 0;

        // reset state
        expect_out(0, 0, 0, 0, "reset");
        expect_out(1, 0, 0, 0, "reset");
        expect_out(2, 0, 0, 0, "reset");
        tick();
        res = 1;

        // wrap, saturate and prescaler (with a 2-cycle en gap) run side by side
        b0.en = 1;
        for (int i = 1; i <= 14; i++) begin
            int k;
            b1.en = (i <= 12);
            b2.en = !(i == 11 || i == 12);
            k = (i <= 10) ? i : ((i <= 12) ? 10 : i - 2);
            expect_out(0, i % 10, i == 10, i >= 10, "wrap");
            expect_out(1, (i < 9) ? i : 9, (i >= 10 && i <= 12), i >= 10, "saturate");
            expect_out(2, k / 3, 0, 0, "prescale");
            tick();
        end

        // clear, then down-count through the zero limit, then flip direction
        b0.en = 0; b1.en = 0; b2.en = 0; b0.clr = 1;
        expect_out(0, 0, 0, 0, "clr");
        expect_out(2, 4, 0, 0, "hold");
        tick();
        b0.clr = 0; b0.en = 1; b0.up = 0;
        for (int i = 1; i <= 4; i++) begin
            expect_out(0, (i == 1) ? 9 : 10 - i, i == 1, 1, "down");
            tick();
        end
        b0.up = 1;
        expect_out(0, 7, 0, 1, "flip");
        tick();

        // load clamp, load clears prescaler, load+clr priority
        b0.en = 0; b2.en = 1;
        expect_out(2, 4, 0, 0, "pre_adv");
        tick();
        b0.load = 1; b0.d = 5;
        b1.load = 1; b1.d = 12; b1.en = 1;
        b2.load = 1; b2.d = 200;
        expect_out(0, 5, 0, 1, "load");
        expect_out(1, 9, 0, 1, "load_clamp");
        expect_out(2, 200, 0, 0, "load_pre");
        tick();
        b0.load = 0; b2.load = 0; b1.clr = 1;
        expect_out(1, 0, 0, 0, "load_clr");
        expect_out(2, 200, 0, 0, "pre_cleared1");
        tick();
        b1.load = 0; b1.clr = 0; b1.en = 0;
        expect_out(2, 200, 0, 0, "pre_cleared2");
        tick();
        expect_out(2, 201, 0, 0, "pre_step");
        tick();

        // res glitch between edges is ignored; res held over an edge resets
        b2.en = 0;
        res = 0;
        #3;
        res = 1;
        expect_out(0, 5, 0, 1, "res_glitch");
        expect_out(2, 201, 0, 0, "res_glitch");
        tick();
        res = 0;
        expect_out(0, 0, 0, 0, "res_sync");
        expect_out(2, 0, 0, 0, "res_sync");
        tick();
        res = 1; b0.en = 1; b0.up = 1;
        expect_out(0, 1, 0, 0, "resume");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
